dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_ram.sv | 36 +++
 rtl/dmem_responder.sv | 145 ++++++++++++++
 tb/tb_dmem_responder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state enum, byte-enable patterns, the wait-counter width
// and the misalignment predicate used when DMEM_ALIGN_CHECK_EN is defined.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  localparam int CNT_W = 4;

  // Misaligned: a full word off a word boundary, or a halfword on an odd byte.
  function automatic logic is_misaligned(input logic [1:0] lo, input logic [3:0] be);
    return ((lo != 2'b00) && (be == BE_WORD)) ||
           (lo[0] && ((be == BE_HALF_LO) || (be == BE_HALF_HI)));
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port DEPTH_WORDS x 32 data array with per-byte-lane writes and a
// registered read port. One access per enabled cycle: write when i_we = 1,
// otherwise read into o_rdata, which holds its value between reads.
module dmem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_we,
  input  logic [3:0]       i_be,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // Byte-lane write into the array.
  // NOTE: the array has no reset so it can map onto a RAM macro; only the read register below is reset.
  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) r_mem[i_idx][i*8 +: 8] <= i_wdata[i*8 +: 8];
      end
    end
  end

  // Registered read; holds the last loaded word when not reading.
  always_ff @(posedge clk) begin
    if (rst)                o_rdata <= '0;
    else if (i_en && !i_we) o_rdata <= r_mem[i_idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts a core load/store, waits WAIT_CYCLES, then
// commits the access on the edge entering RESP and pulses ready for one cycle.
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag misaligned accesses on
// err and suppress misaligned stores; otherwise err is tied to 0.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        stall,
  output logic        err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  state_t             r_state, w_next_state, w_eff_state;
  logic [CNT_W-1:0]   r_cnt, w_next_cnt;
  logic               r_we;
  logic [IDX_W-1:0]   r_idx;
  logic [31:0]        r_wdata;
  logic [3:0]         r_be;

  logic               w_in_idle;
  logic               w_sel_we;
  logic [IDX_W-1:0]   w_sel_idx;
  logic [31:0]        w_sel_wdata;
  logic [3:0]         w_sel_be;
  logic               w_commit;
  logic               w_misaligned;
  logic               w_ram_en;
  logic               w_unused;

  // Next-state and counter logic.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_next_cnt   = WAIT_INIT;
          w_next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        w_next_cnt = r_cnt - 1'b1;
        if (r_cnt <= 1) w_next_state = RESP;
      end
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State and wait-counter registers.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Capture the request on the accepting edge; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst && (r_state == IDLE) && req) begin
      r_we    <= we;
      r_idx   <= addr[IDX_W+1:2];
      r_wdata <= wdata;
      r_be    <= be;
    end
  end

  // With zero wait states the commit edge is the accepting edge, so the
  // array is fed from the live inputs in IDLE and from the captures otherwise.
  assign w_in_idle   = (r_state == IDLE);
  assign w_sel_we    = w_in_idle ? we               : r_we;
  assign w_sel_idx   = w_in_idle ? addr[IDX_W+1:2]  : r_idx;
  assign w_sel_wdata = w_in_idle ? wdata            : r_wdata;
  assign w_sel_be    = w_in_idle ? be               : r_be;

  // Commit edge: the edge entering RESP, cancelled by a coincident reset.
  assign w_commit = !rst && (r_state != RESP) && (w_next_state == RESP);

`ifdef DMEM_ALIGN_CHECK_EN
  logic [1:0] r_lo;
  logic       r_err;

  // Low address bits are only needed for the alignment check.
  always_ff @(posedge clk) begin
    if (!rst && (r_state == IDLE) && req) r_lo <= addr[1:0];
  end

  assign w_misaligned = is_misaligned(w_in_idle ? addr[1:0] : r_lo, w_sel_be);

  // err is registered on the commit edge so it is valid alongside ready.
  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_commit && w_misaligned;
  end

  assign err      = r_err;
  assign w_unused = ^addr[31:IDX_W+2];
`else
  assign w_misaligned = 1'b0;
  assign err          = 1'b0;
  assign w_unused     = ^{addr[31:IDX_W+2], addr[1:0]};
`endif

  // A suppressed (misaligned) store must not fall through into a read.
  assign w_ram_en = w_commit && !(w_sel_we && w_misaligned);

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_ram_en),
    .i_we    (w_sel_we),
    .i_be    (w_sel_be),
    .i_idx   (w_sel_idx),
    .i_wdata (w_sel_wdata),
    .o_rdata (rdata)
  );

  // During reset the hazard unit sees the block as already idle.
  assign w_eff_state = rst ? IDLE : r_state;
  assign stall       = ((w_eff_state == IDLE) && req) || (w_eff_state == WAIT);
  assign ready       = (r_state == RESP);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with WAIT_CYCLES = 2 and
// one with WAIT_CYCLES = 0. Drivers push expected responses; per-instance
// monitors pop and compare whenever ready is seen.
module tb_dmem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        stall [2];
  logic        err   [2];

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] last_rd [2];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .be(be[0]), .rdata(rdata[0]), .ready(ready[0]),
    .stall(stall[0]), .err(err[0])
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .be(be[1]), .rdata(rdata[1]), .ready(ready[1]),
    .stall(stall[1]), .err(err[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: compare each ready pulse against the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (ready[0] === 1'b1) begin
      if (q0.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL w2_unexpected_ready: got ready=1 expected no response at %0t", $time);
      end else begin
        e = q0.pop_front();
        check("w2_rdata", rdata[0], e.rdata);
        check("w2_err", {31'b0, err[0]}, {31'b0, e.err});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ready[1] === 1'b1) begin
      if (q1.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL w0_unexpected_ready: got ready=1 expected no response at %0t", $time);
      end else begin
        e = q1.pop_front();
        check("w0_rdata", rdata[1], e.rdata);
        check("w0_err", {31'b0, err[1]}, {31'b0, e.err});
      end
    end
  end

  // One access on instance d. exp_rd is the load result (ignored for stores,
  // which must leave rdata at its previous value). hold keeps req high for a
  // back-to-back follower; disturb scrambles the inputs while in WAIT.
  task automatic access(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] b,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input logic hold, input logic disturb);
    exp_t e;
    int   n;
    int   stalls;
    bit   done;
    int   lat;
    lat = (d == 0) ? 3 : 1;
    @(posedge clk); #1;
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
    if (!w) last_rd[d] = exp_rd;
    e.rdata = last_rd[d];
    e.err   = exp_err;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    n = 0; stalls = 0; done = 1'b0;
    while (!done && n < 40) begin
      @(negedge clk);
      if (ready[d] === 1'b1) begin
        done = 1'b1;
        check("stall_in_resp", {31'b0, stall[d]}, 32'd0);
      end else begin
        if (stall[d] === 1'b1) stalls++;
        n++;
        if (disturb && n == 2) begin
          req[d] = 1'b0; addr[d] = a + 32'd4; wdata[d] = ~wd; be[d] = ~b; we[d] = ~w;
        end
      end
    end
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL timeout: got no ready within 40 cycles expected ready after %0d", lat);
    end else begin
      check("latency", n, lat);
      check("stall_cycles", stalls, lat);
    end
    if (!hold) req[d] = 1'b0;
  endtask

  localparam logic [31:0] ZW_DATA [4] = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};

  initial begin
    int wait_n;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0; be[i] = '0; last_rd[i] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    req[0] = 1'b1; #1;
    check("rst_stall_follows_req", {31'b0, stall[0]}, 32'd1);
    req[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'b0, ready[0]}, 32'd0);
    check("rst_rdata", rdata[0], 32'd0);
    check("rst_err", {31'b0, err[0]}, 32'd0);
    check("rst_stall_idle", {31'b0, stall[0]}, 32'd0);

    // Store then load.
    access(0, 1, 32'h10, 32'hDEADBEEF, 4'b1111, '0, 1'b0, 1'b0, 1'b0);
    access(0, 0, 32'h10, '0, 4'b1111, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);

    // Partial store, then an all-lanes-off store that changes nothing.
    access(0, 1, 32'h20, 32'h11223344, 4'b1111, '0, 1'b0, 1'b0, 1'b0);
    access(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, '0, 1'b0, 1'b0, 1'b0);
    access(0, 0, 32'h20, '0, 4'b1111, 32'h11BB33DD, 1'b0, 1'b0, 1'b0);
    access(0, 1, 32'h20, 32'hFFFFFFFF, 4'b0000, '0, 1'b0, 1'b0, 1'b0);
    access(0, 0, 32'h20, '0, 4'b1111, 32'h11BB33DD, 1'b0, 1'b0, 1'b0);

    // Inputs changed during WAIT are ignored.
    access(0, 1, 32'h50, 32'h0BADF00D, 4'b1111, '0, 1'b0, 1'b0, 1'b1);
    access(0, 0, 32'h50, '0, 4'b1111, 32'h0BADF00D, 1'b0, 1'b0, 1'b0);

    // Reset on the second WAIT cycle aborts the store.
    access(0, 1, 32'h30, 32'hA5A5A5A5, 4'b1111, '0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h30; wdata[0] = 32'h12345678; be[0] = 4'b1111;
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_stall_in_rst", {31'b0, stall[0]}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;
    @(negedge clk);
    check("abort_ready", {31'b0, ready[0]}, 32'd0);
    check("abort_idle_stall", {31'b0, stall[0]}, 32'd0);
    check("abort_rdata", rdata[0], 32'd0);
    access(0, 0, 32'h30, '0, 4'b1111, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);

    // Address wrap past DEPTH_WORDS.
    access(0, 1, 32'h00001004, 32'hCAFEF00D, 4'b1111, '0, 1'b0, 1'b0, 1'b0);
    access(0, 0, 32'h00000004, '0, 4'b1111, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0);

    // Misaligned word store: flagged and suppressed when the check is built in.
    access(0, 1, 32'h40, 32'h55667788, 4'b1111, '0, 1'b0, 1'b0, 1'b0);
    access(0, 1, 32'h42, 32'hFFFFFFFF, 4'b1111, '0, ALIGN, 1'b0, 1'b0);
    access(0, 0, 32'h40, '0, 4'b1111, ALIGN ? 32'h55667788 : 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    access(0, 0, 32'h41, '0, 4'b0011, ALIGN ? 32'h55667788 : 32'hFFFFFFFF, ALIGN, 1'b0, 1'b0);

    // Zero-wait instance: fill, then back-to-back loads with req held high.
    for (int i = 0; i < 4; i++)
      access(1, 1, 32'(i * 4), ZW_DATA[i], 4'b1111, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      access(1, 0, 32'(i * 4), '0, 4'b1111, ZW_DATA[i], 1'b0, (i < 3), 1'b0);

    wait_n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL drain: got %0d responses outstanding expected 0", q0.size() + q1.size());
    end
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
